// File: rtl/rob_param_commit_if.sv
// Reorder buffer bundle: issue, writeback, operand query and commit/flush signals.
interface rob_param_commit_if #(
  parameter int unsigned ROB_ADDR = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_WB   = 2
);
  logic                       iss_valid;
  logic [1:0]                 iss_type;
  logic [4:0]                 iss_rd;
  logic [XLEN-1:0]            iss_pred_pc;
  logic [ROB_ADDR-1:0]        iss_idx;
  logic                       rob_full;
  logic                       rob_empty;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*ROB_ADDR-1:0] wb_idx;
  logic [NUM_WB*XLEN-1:0]     wb_value;
  logic [NUM_WB*XLEN-1:0]     wb_next_pc;
  logic [ROB_ADDR-1:0]        q1_idx;
  logic [ROB_ADDR-1:0]        q2_idx;
  logic                       q1_ready;
  logic                       q2_ready;
  logic [XLEN-1:0]            q1_value;
  logic [XLEN-1:0]            q2_value;
  logic                       commit_valid;
  logic [ROB_ADDR-1:0]        commit_idx;
  logic [4:0]                 commit_rd;
  logic [XLEN-1:0]            commit_value;
  logic                       commit_store;
  logic                       flush_out;
  logic [XLEN-1:0]            flush_pc;

  modport slave (
    input  iss_valid, iss_type, iss_rd, iss_pred_pc,
    input  wb_valid, wb_idx, wb_value, wb_next_pc,
    input  q1_idx, q2_idx,
    output iss_idx, rob_full, rob_empty,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_idx, commit_rd, commit_value, commit_store,
    output flush_out, flush_pc
  );

  modport master (
    output iss_valid, iss_type, iss_rd, iss_pred_pc,
    output wb_valid, wb_idx, wb_value, wb_next_pc,
    output q1_idx, q2_idx,
    input  iss_idx, rob_full, rob_empty,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_idx, commit_rd, commit_value, commit_store,
    input  flush_out, flush_pc
  );
endinterface

// File: rtl/rob_param_commit.sv
// Reorder buffer: in-order allocate, out-of-order writeback on NUM_WB channels,
// in-order single commit with branch mispredict flush and bypassed operand queries.
module rob_param_commit #(
  parameter int unsigned ROB_ADDR = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_WB   = 2
) (
  input logic                 clk_in,
  input logic                 rst_in,
  input logic                 rdy_in,
  rob_param_commit_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ROB_ADDR;
  localparam logic [1:0] TypeStore  = 2'd1;
  localparam logic [1:0] TypeBranch = 2'd2;

  logic                busy_q  [DEPTH];
  logic                busy_d  [DEPTH];
  logic                ready_q [DEPTH];
  logic                ready_d [DEPTH];
  logic [1:0]          type_q  [DEPTH];
  logic [1:0]          type_d  [DEPTH];
  logic [4:0]          rd_q    [DEPTH];
  logic [4:0]          rd_d    [DEPTH];
  logic [XLEN-1:0]     pred_q  [DEPTH];
  logic [XLEN-1:0]     pred_d  [DEPTH];
  logic [XLEN-1:0]     value_q [DEPTH];
  logic [XLEN-1:0]     value_d [DEPTH];
  logic [XLEN-1:0]     npc_q   [DEPTH];
  logic [XLEN-1:0]     npc_d   [DEPTH];
  logic [ROB_ADDR-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR:0]   count_q, count_d;

  logic                commit_valid_q, commit_valid_d, commit_store_q, commit_store_d;
  logic [ROB_ADDR-1:0] commit_idx_q, commit_idx_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]     commit_value_q, commit_value_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     flush_pc_q, flush_pc_d;

  logic                full, do_issue, do_commit, mispredict;

  logic [ROB_ADDR-1:0] wb_idx_a [NUM_WB];
  logic [XLEN-1:0]     wb_val_a [NUM_WB];
  logic [XLEN-1:0]     wb_npc_a [NUM_WB];

  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_unpack
    assign wb_idx_a[g] = bus.wb_idx[g*ROB_ADDR +: ROB_ADDR];
    assign wb_val_a[g] = bus.wb_value[g*XLEN +: XLEN];
    assign wb_npc_a[g] = bus.wb_next_pc[g*XLEN +: XLEN];
  end

  assign full          = (count_q == (ROB_ADDR+1)'(DEPTH));
  assign bus.rob_full  = full;
  assign bus.rob_empty = (count_q == '0);
  assign bus.iss_idx   = tail_q;

  assign do_issue   = rdy_in && bus.iss_valid && !full;
  assign do_commit  = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign mispredict = do_commit && (type_q[head_q] == TypeBranch) &&
                      (npc_q[head_q] != pred_q[head_q]);

  // Stored ready/value, overridden by a live writeback (highest channel wins).
  function automatic logic [XLEN:0] query(input logic [ROB_ADDR-1:0] q);
    logic [XLEN:0] r;
    r = {1'b0, value_q[q]};
    if (busy_q[q]) begin
      r[XLEN] = ready_q[q];
      for (int ch = 0; ch < NUM_WB; ch++) begin
        if (rdy_in && bus.wb_valid[ch] && wb_idx_a[ch] == q) r = {1'b1, wb_val_a[ch]};
      end
    end
    return r;
  endfunction

  // Combinational operand queries.
  always_comb begin
    {bus.q1_ready, bus.q1_value} = query(bus.q1_idx);
    {bus.q2_ready, bus.q2_value} = query(bus.q2_idx);
  end

  // Next state: writeback, then commit/flush, then allocate.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    type_d  = type_q;
    rd_d    = rd_q;
    pred_d  = pred_q;
    value_d = value_q;
    npc_d   = npc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    commit_valid_d = 1'b0;
    commit_store_d = 1'b0;
    flush_d        = 1'b0;
    commit_idx_d   = commit_idx_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    flush_pc_d     = flush_pc_q;
    if (rdy_in) begin
      for (int ch = 0; ch < NUM_WB; ch++) begin
        if (bus.wb_valid[ch] && busy_q[wb_idx_a[ch]]) begin
          ready_d[wb_idx_a[ch]] = 1'b1;
          value_d[wb_idx_a[ch]] = wb_val_a[ch];
          npc_d[wb_idx_a[ch]]   = wb_npc_a[ch];
        end
      end
      if (do_commit) begin
        commit_valid_d  = 1'b1;
        commit_idx_d    = head_q;
        commit_store_d  = (type_q[head_q] == TypeStore);
        commit_rd_d     = (type_q[head_q] == TypeStore) ? 5'd0 : rd_q[head_q];
        commit_value_d  = value_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + ROB_ADDR'(1);
      end
      if (mispredict) begin
        flush_d    = 1'b1;
        flush_pc_d = npc_q[head_q];
        for (int i = 0; i < DEPTH; i++) begin
          busy_d[i]  = 1'b0;
          ready_d[i] = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (do_issue) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          type_d[tail_q]  = bus.iss_type;
          rd_d[tail_q]    = bus.iss_rd;
          pred_d[tail_q]  = bus.iss_pred_pc;
          tail_d          = tail_q + ROB_ADDR'(1);
        end
        count_d = count_q + (ROB_ADDR+1)'(do_issue) - (ROB_ADDR+1)'(do_commit);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
        type_q[i]  <= '0;
        rd_q[i]    <= '0;
        pred_q[i]  <= '0;
        value_q[i] <= '0;
        npc_q[i]   <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_store_q <= 1'b0;
      commit_idx_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      type_q         <= type_d;
      rd_q           <= rd_d;
      pred_q         <= pred_d;
      value_q        <= value_d;
      npc_q          <= npc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_store_q <= commit_store_d;
      commit_idx_q   <= commit_idx_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_store = commit_store_q;
  assign bus.commit_idx   = commit_idx_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.flush_out    = flush_q;
  assign bus.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_rob_param_commit.sv
// Bench for rob_param_commit: queue-based reference model with a per-cycle comparator,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_param_commit;
  localparam int unsigned RA = 4, XL = 32, NW = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  rob_param_commit_if #(.ROB_ADDR(RA), .XLEN(XL), .NUM_WB(NW)) bus ();

  rob_param_commit #(.ROB_ADDR(RA), .XLEN(XL), .NUM_WB(NW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the live entries in program order.
  typedef struct {
    int          idx;
    int          typ;
    int          rd;
    logic [31:0] pred;
    bit          ready;
    logic [31:0] value;
    logic [31:0] npc;
  } ent_t;

  ent_t        mq[$];
  int          m_tail = 0;
  bit          e_cv = 0, e_cs = 0, e_fl = 0;
  int          e_cidx = 0, e_crd = 0;
  logic [31:0] e_cval = 0, e_fpc = 0;

  function automatic int find(input int idx);
    foreach (mq[k]) if (mq[k].idx == idx) return k;
    return -1;
  endfunction

  function automatic int wbi(input int ch);
    return int'(bus.wb_idx[ch*RA +: RA]);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    ent_t cap;
    ent_t ne;
    bit   dc, di;
    int   p;
    if (rst) begin
      mq.delete();
      m_tail = 0;
      e_cv = 0; e_cs = 0; e_fl = 0;
      e_cidx = 0; e_crd = 0; e_cval = 0; e_fpc = 0;
    end else if (!rdy) begin
      e_cv = 0; e_cs = 0; e_fl = 0;
    end else begin
      di = bus.iss_valid && (mq.size() < DEPTH);
      dc = (mq.size() > 0) && mq[0].ready;
      if (dc) cap = mq[0];
      for (int ch = 0; ch < NW; ch++) begin
        if (bus.wb_valid[ch]) begin
          p = find(wbi(ch));
          if (p >= 0) begin
            mq[p].ready = 1;
            mq[p].value = bus.wb_value[ch*XL +: XL];
            mq[p].npc   = bus.wb_next_pc[ch*XL +: XL];
          end
        end
      end
      e_cv = dc;
      e_cs = 0;
      e_fl = 0;
      if (dc) begin
        void'(mq.pop_front());
        e_cidx = cap.idx;
        e_cs   = (cap.typ == 1);
        e_crd  = (cap.typ == 1) ? 0 : cap.rd;
        e_cval = cap.value;
        if (cap.typ == 2 && cap.npc != cap.pred) begin
          e_fl  = 1;
          e_fpc = cap.npc;
          mq.delete();
          m_tail = 0;
        end
      end
      if (!e_fl && di) begin
        ne.idx = m_tail; ne.typ = int'(bus.iss_type); ne.rd = int'(bus.iss_rd);
        ne.pred = bus.iss_pred_pc; ne.ready = 0; ne.value = 0; ne.npc = 0;
        mq.push_back(ne);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  function automatic void qexp(input int q, output bit r, output logic [31:0] v);
    int p;
    p = find(q);
    r = 0;
    v = 0;
    if (p < 0) return;
    r = mq[p].ready;
    v = mq[p].value;
    if (rdy) begin
      for (int ch = 0; ch < NW; ch++) begin
        if (bus.wb_valid[ch] && wbi(ch) == q) begin
          r = 1;
          v = bus.wb_value[ch*XL +: XL];
        end
      end
    end
  endfunction

  // Comparator: every falling edge outside reset.
  always @(negedge clk) begin : compare
    bit          r;
    logic [31:0] v;
    if (!rst) begin
      chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
      chk("commit_store", 32'(bus.commit_store), 32'(e_cs));
      chk("flush_out", 32'(bus.flush_out), 32'(e_fl));
      if (e_cv) begin
        chk("commit_idx", 32'(bus.commit_idx), 32'(e_cidx));
        chk("commit_rd", 32'(bus.commit_rd), 32'(e_crd));
        chk("commit_value", bus.commit_value, e_cval);
      end
      if (e_fl) chk("flush_pc", bus.flush_pc, e_fpc);
      chk("iss_idx", 32'(bus.iss_idx), 32'(m_tail));
      chk("rob_full", 32'(bus.rob_full), 32'(mq.size() == DEPTH));
      chk("rob_empty", 32'(bus.rob_empty), 32'(mq.size() == 0));
      qexp(int'(bus.q1_idx), r, v);
      chk("q1_ready", 32'(bus.q1_ready), 32'(r));
      if (r) chk("q1_value", bus.q1_value, v);
      qexp(int'(bus.q2_idx), r, v);
      chk("q2_ready", 32'(bus.q2_ready), 32'(r));
      if (r) chk("q2_value", bus.q2_value, v);
    end
  end

  task automatic clr();
    bus.iss_valid   = 0;
    bus.iss_type    = 0;
    bus.iss_rd      = 0;
    bus.iss_pred_pc = 32'h100;
    bus.wb_valid    = '0;
    bus.wb_idx      = '0;
    bus.wb_value    = '0;
    bus.wb_next_pc  = '0;
    bus.q1_idx      = '0;
    bus.q2_idx      = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    clr();
  endtask

  task automatic issue(input int typ, input int rd);
    bus.iss_valid   = 1;
    bus.iss_type    = 2'(typ);
    bus.iss_rd      = 5'(rd);
    bus.iss_pred_pc = 32'h100;
    cyc();
    clr();
  endtask

  task automatic set_wb(input int ch, input int idx, input logic [31:0] val,
                        input logic [31:0] npc);
    bus.wb_valid[ch]          = 1'b1;
    bus.wb_idx[ch*RA +: RA]   = RA'(idx);
    bus.wb_value[ch*XL +: XL] = val;
    bus.wb_next_pc[ch*XL +: XL] = npc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    clr();
    rdy = 1;
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    // Reset state.
    chk("rst_empty", 32'(bus.rob_empty), 1);
    chk("rst_full", 32'(bus.rob_full), 0);
    chk("rst_iss_idx", 32'(bus.iss_idx), 0);
    chk("rst_commit_valid", 32'(bus.commit_valid), 0);
    chk("rst_commit_rd", 32'(bus.commit_rd), 0);
    chk("rst_commit_value", bus.commit_value, 0);
    chk("rst_flush_pc", bus.flush_pc, 0);

    // 1: reset in the middle of operation with three busy entries.
    issue(0, 1); issue(0, 2); issue(0, 3);
    chk("t1_iss_idx", 32'(bus.iss_idx), 3);
    set_wb(0, 0, 32'h11, 32'h0);
    rst = 1;
    #1;
    chk("t1_async_empty", 32'(bus.rob_empty), 1);
    chk("t1_async_iss_idx", 32'(bus.iss_idx), 0);
    cyc();
    rst = 0;
    clr();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_no_commit", 32'(bus.commit_valid), 0);
      chk("t1_no_flush", 32'(bus.flush_out), 0);
    end

    // 2: fill, overflow attempt, then first commit.
    for (int i = 0; i < 16; i++) issue(0, i + 1);
    chk("t2_full", 32'(bus.rob_full), 1);
    chk("t2_iss_idx_wrapped", 32'(bus.iss_idx), 0);
    issue(0, 20);
    chk("t2_full_after_17th", 32'(bus.rob_full), 1);
    set_wb(0, 0, 32'h55, 32'h0);
    cyc();
    clr();
    chk("t2_no_commit_on_wb_edge", 32'(bus.commit_valid), 0);
    cyc();
    chk("t2_commit_valid", 32'(bus.commit_valid), 1);
    chk("t2_commit_idx", 32'(bus.commit_idx), 0);
    chk("t2_commit_rd", 32'(bus.commit_rd), 1);
    chk("t2_commit_value", bus.commit_value, 32'h55);
    chk("t2_not_full", 32'(bus.rob_full), 0);

    // 3: out-of-order writeback, in-order commit.
    do_reset();
    issue(0, 5); issue(0, 6); issue(0, 7);
    set_wb(0, 2, 32'h22, 0); cyc(); clr();
    set_wb(0, 1, 32'h21, 0); cyc(); clr();
    chk("t3_blocked_by_head", 32'(bus.commit_valid), 0);
    set_wb(0, 0, 32'h20, 0); cyc(); clr();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_commit_valid", 32'(bus.commit_valid), 1);
      chk("t3_commit_idx", 32'(bus.commit_idx), 32'(i));
      chk("t3_commit_value", bus.commit_value, 32'h20 + 32'(i));
    end

    // 4: mispredicted branch flushes younger entries.
    do_reset();
    issue(2, 0); issue(0, 8); issue(0, 9);
    set_wb(0, 0, 32'h0, 32'h200); cyc(); clr();
    bus.iss_valid = 1;
    set_wb(1, 1, 32'h77, 32'h0);
    cyc();
    clr();
    chk("t4_flush", 32'(bus.flush_out), 1);
    chk("t4_flush_pc", bus.flush_pc, 32'h200);
    chk("t4_empty", 32'(bus.rob_empty), 1);
    chk("t4_iss_idx", 32'(bus.iss_idx), 0);
    cyc();
    chk("t4_flush_pulse", 32'(bus.flush_out), 0);
    chk("t4_still_empty", 32'(bus.rob_empty), 1);

    // 5: both channels on one index; higher channel wins.
    do_reset();
    for (int i = 0; i < 4; i++) issue(0, i + 1);
    set_wb(0, 3, 32'hA, 0);
    set_wb(1, 3, 32'hB, 0);
    bus.q1_idx = 4'd3;
    #1;
    chk("t5_q1_ready", 32'(bus.q1_ready), 1);
    chk("t5_q1_value", bus.q1_value, 32'hB);
    cyc(); clr();
    set_wb(0, 0, 32'h1, 0); set_wb(1, 1, 32'h2, 0); cyc(); clr();
    set_wb(0, 2, 32'h3, 0); cyc(); clr();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.commit_valid && bus.commit_idx == 4'd3) begin
        found = 1;
        chk("t5_commit_value", bus.commit_value, 32'hB);
      end else cyc();
    end
    if (!found) chk("t5_commit_seen", 0, 1);

    // 6: store commit, then wrap-around sequence.
    do_reset();
    issue(1, 9);
    set_wb(1, 0, 32'h1, 0); cyc(); clr();
    cyc();
    chk("t6_commit_valid", 32'(bus.commit_valid), 1);
    chk("t6_commit_store", 32'(bus.commit_store), 1);
    chk("t6_commit_rd", 32'(bus.commit_rd), 0);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      chk("t6_wrap_iss_idx", 32'(bus.iss_idx), 32'(i % 16));
      issue(0, (i % 31) + 1);
      set_wb(0, i % 16, 32'(i), 0); cyc(); clr();
      cyc();
      chk("t6_wrap_commit_valid", 32'(bus.commit_valid), 1);
      chk("t6_wrap_commit_idx", 32'(bus.commit_idx), 32'(i % 16));
      chk("t6_wrap_commit_value", bus.commit_value, 32'(i));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
        clr();
        cyc();
        rst = 0;
        continue;
      end
      rdy             = ($urandom_range(0, 9) != 0);
      bus.iss_valid   = ($urandom_range(0, 9) < 6);
      bus.iss_type    = 2'($urandom_range(0, 2));
      bus.iss_rd      = 5'($urandom);
      bus.iss_pred_pc = 32'h100;
      for (int ch = 0; ch < NW; ch++) begin
        bus.wb_valid[ch] = 1'b0;
        if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
          set_wb(ch, mq[$urandom_range(0, mq.size() - 1)].idx, $urandom,
                 ($urandom_range(0, 5) == 0) ? 32'h200 + 32'($urandom_range(0, 15) * 4)
                                             : 32'h100);
        end else if ($urandom_range(0, 3) == 0) begin
          set_wb(ch, $urandom_range(0, 15), $urandom, 32'h100);
        end
      end
      bus.q1_idx = 4'($urandom);
      bus.q2_idx = (mq.size() > 0) ? 4'(mq[$urandom_range(0, mq.size() - 1)].idx)
                                   : 4'($urandom);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
